// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Drives the ROI/POI fetch stage during mosaic stitching. A start pulse in
// IDLE launches a sweep over every POI of the core grid. Each POI gets
// WIN_ROWS window-row reads. The ROI address of the first pixel of each
// window row is derived from the POI grid position. Data returning from the
// fetch stage one cycle after each issue is tagged with valid/last flags.
//
// Handshake: `stall` is downstream backpressure. In RUN, `en` is the issue
// strobe and equals !stall in the same cycle, so a row issues exactly in the
// cycles where en=1. Counters and addresses only move on an issue, so a
// stalled row is presented again, unchanged, in the next cycle.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   start          in   begin a sweep (sampled only in IDLE)
//   stall          in   downstream backpressure
//   en             out  issue strobe (combinational from stall in RUN)
//   w_addr_re      out  ROI address {row, col} of the window row's first pixel
//   POI_addr_re    out  POI index {py, px}
//   w_row          out  window row index
//   out_valid      out  fetch outputs carry valid data this cycle
//   out_poi_last   out  valid data is the last row of a POI
//   out_frame_last out  valid data is the last row of the last POI
//   busy           out  sweep in progress (RUN, DRAIN, DONE)
//   done           out  one-cycle completion pulse
//   dbg_state      out  current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int ROI_DEPTH = 6,
    parameter int ROI_WIDTH = 6,
    parameter int POI_DEPTH = 4,
    parameter int POI_WIDTH = 4,
    parameter int WIN_ROWS  = 32,
    parameter int WIN_COLS  = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stall,
    output logic                           en,
    output logic [ROI_DEPTH+ROI_WIDTH-1:0] w_addr_re,
    output logic [POI_DEPTH+POI_WIDTH-1:0] POI_addr_re,
    output logic [4:0]                     w_row,
    output logic                           out_valid,
    output logic                           out_poi_last,
    output logic                           out_frame_last,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     dbg_state
);

    localparam int PW = POI_DEPTH + POI_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] ROW_LAST = 5'(WIN_ROWS - 1);

    // Rightmost column at which a full WIN_COLS-wide window still fits.
    localparam logic [ROI_WIDTH-1:0] OX_MAX = ROI_WIDTH'((1 << ROI_WIDTH) - WIN_COLS);

    state_t         state;
    logic [4:0]     row_cnt;
    logic [PW-1:0]  poi_cnt;

    logic           row_last;
    logic           poi_last;

    logic [POI_DEPTH-1:0] py;
    logic [POI_WIDTH-1:0] px;
    logic [ROI_DEPTH-1:0] oy;
    logic [ROI_WIDTH-1:0] ox_raw;
    logic [ROI_WIDTH-1:0] ox;
    logic [ROI_DEPTH-1:0] row;

    assign row_last = (row_cnt == ROW_LAST);
    assign poi_last = (poi_cnt == {PW{1'b1}});

    // The only combinational output: issue follows stall in the same cycle.
    assign en = (state == RUN) && !stall;

    // Address generation straight from the registered counters. In IDLE the
    // counters are cleared, and after the final issue they have wrapped to
    // zero, so the addresses read zero outside RUN.
    assign py     = poi_cnt[PW-1:POI_WIDTH];
    assign px     = poi_cnt[POI_WIDTH-1:0];
    assign oy     = ROI_DEPTH'(py) << (ROI_DEPTH - POI_DEPTH);
    assign ox_raw = ROI_WIDTH'(px) << (ROI_WIDTH - POI_WIDTH);
    assign ox     = (ox_raw > OX_MAX) ? OX_MAX : ox_raw;
    // Truncation is intentional: window rows wrap modulo the ROI height.
    assign row    = oy + ROI_DEPTH'(row_cnt);

    assign w_addr_re   = {row, ox};
    assign POI_addr_re = poi_cnt;
    assign w_row       = row_cnt;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            row_cnt        <= '0;
            poi_cnt        <= '0;
            out_valid      <= 1'b0;
            out_poi_last   <= 1'b0;
            out_frame_last <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            // Return tagging lines up with the fetch stage's one-cycle latency.
            out_valid      <= en;
            out_poi_last   <= en && row_last;
            out_frame_last <= en && row_last && poi_last;
            done           <= 1'b0;

            case (state)
                IDLE: begin
                    row_cnt <= '0;
                    poi_cnt <= '0;
                    busy    <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end

                RUN: begin
                    if (en) begin
                        if (row_last) begin
                            row_cnt <= '0;
                            // poi_cnt wraps to zero after the final POI.
                            poi_cnt <= poi_cnt + 1'b1;
                            if (poi_last) begin
                                state <= DRAIN;
                            end
                        end else begin
                            row_cnt <= row_cnt + 5'd1;
                        end
                    end
                end

                // One cycle for the last fetch result to emerge.
                DRAIN: begin
                    state <= DONE;
                    done  <= 1'b1;
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed sequence of sweeps (unstalled, random 30% stall, start held high
// with a mid-sweep reset, stall on the final issue). Expected issue stream is
// computed from the grid/window arithmetic and queued per sweep; control
// outputs are predicted from the sweep timing rules (issue count, stall
// cycles, drain/done cycles after the final issue).
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int TOTAL = 256 * 32;
  localparam int SBW   = 25;  // {poi[7:0], row[4:0], addr[11:0]}

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        en;
  logic [11:0] w_addr_re;
  logic [7:0]  POI_addr_re;
  logic [4:0]  w_row;
  logic        out_valid;
  logic        out_poi_last;
  logic        out_frame_last;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stall          (stall),
    .en             (en),
    .w_addr_re      (w_addr_re),
    .POI_addr_re    (POI_addr_re),
    .w_row          (w_row),
    .out_valid      (out_valid),
    .out_poi_last   (out_poi_last),
    .out_frame_last (out_frame_last),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [SBW-1:0] exp_q[$];
  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  // reference model of the sweep
  bit model_ok = 0;
  bit active = 0;
  int issued = 0;
  int post = 0;
  bit prev_en = 0;
  bit prev_row_last = 0;
  bit prev_frame_last = 0;
  int start_cyc = 0;

  // per-sweep observations of the DUT
  int n_en, n_ov, n_pl, n_fl, n_done, n_stall, done_cyc;
  bit prev_busy = 0;
  int rise_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected issue k of a sweep: POI k/WIN_ROWS, row k%WIN_ROWS, window origin
  // at the POI's grid position scaled to ROI space, column clamped so the
  // 32-wide window fits the 64-wide ROI, row wrapped modulo 64.
  function automatic logic [SBW-1:0] ref_entry(input int k);
    int poi, r, py, px, oy, ox, arow;
    poi  = k / 32;
    r    = k % 32;
    py   = poi / 16;
    px   = poi % 16;
    oy   = py * (64 / 16);
    ox   = px * (64 / 16);
    if (ox > 64 - 32) ox = 64 - 32;
    arow = (oy + r) % 64;
    return {8'(poi), 5'(r), 12'(arow * 64 + ox)};
  endfunction

  task automatic monitor();
    bit in_run, e_en, e_done;
    logic [SBW-1:0] obs, exp_e;
    in_run = active && (issued < TOTAL);
    e_en   = in_run && !stall;
    e_done = active && (issued == TOTAL) && (post == 1);

    check("en", en, e_en);
    check("busy", busy, active);
    check("done", done, e_done);
    check("out_valid", out_valid, prev_en);
    check("out_poi_last", out_poi_last, prev_en && prev_row_last);
    check("out_frame_last", out_frame_last, prev_en && prev_frame_last);

    obs   = {POI_addr_re, w_row, w_addr_re};
    exp_e = (in_run && exp_q.size() > 0) ? exp_q[0] : '0;
    check("addr_stream", obs, exp_e);
    if (e_en && exp_q.size() > 0) void'(exp_q.pop_front());

    if (e_en) begin
      case (issued)
        16'h5A * 32 + 3: check("addr_poi5A_row3", w_addr_re, 12'h5E0);
        16'hF0 * 32 + 5: check("addr_poiF0_row5", w_addr_re, 12'h040);
        16'h07 * 32 + 0: check("addr_poi07_row0", w_addr_re, 12'h01C);
        default: ;
      endcase
    end

    if (en === 1'b1) n_en++;
    if (out_valid === 1'b1) n_ov++;
    if (out_poi_last === 1'b1) n_pl++;
    if (out_frame_last === 1'b1) n_fl++;
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (in_run && stall) n_stall++;
    if (busy === 1'b1 && !prev_busy) rise_q.push_back(cyc);
    prev_busy = (busy === 1'b1);

    if (e_done) begin
      check("sweep_en_count", n_en, TOTAL);
      check("sweep_valid_count", n_ov, TOTAL);
      check("sweep_poi_last_count", n_pl, 256);
      check("sweep_frame_last_count", n_fl, 1);
      check("sweep_done_count", n_done, 1);
      check("sweep_latency", done_cyc - start_cyc, 8194 + n_stall);
    end
  endtask

  task automatic update_model(input logic st, input logic rs);
    bit in_run, e_en, was_done_phase;
    if (rs) begin
      model_ok = 1;
      active = 0;
      issued = 0;
      post = 0;
      prev_en = 0;
      prev_row_last = 0;
      prev_frame_last = 0;
      exp_q.delete();
      return;
    end
    in_run = active && (issued < TOTAL);
    e_en   = in_run && !stall;
    prev_en         = e_en;
    prev_row_last   = (issued % 32) == 31;
    prev_frame_last = (issued == TOTAL - 1);
    was_done_phase  = active && (issued == TOTAL);
    if (e_en) issued++;
    if (!active) begin
      if (st) begin
        active = 1;
        issued = 0;
        post = 0;
        start_cyc = cyc;
        n_en = 0; n_ov = 0; n_pl = 0; n_fl = 0; n_done = 0; n_stall = 0; done_cyc = 0;
        exp_q.delete();
        for (int k = 0; k < TOTAL; k++) exp_q.push_back(ref_entry(k));
      end
    end else if (was_done_phase) begin
      if (post == 1) active = 0;
      else post++;
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic tick(input logic st, input logic sl, input logic rs);
    start = st;
    stall = sl;
    reset = rs;
    #1;
    if (model_ok) monitor();
    update_model(st, rs);
    @(negedge clk);
    cyc++;
  endtask

  // mode 0: no stall, 1: random 30% stall, 2: stall 3 cycles on final issue
  task automatic run_sweep(input int mode, input logic hold, input int abort_at);
    int budget;
    int fs;
    logic sl;
    budget = 20000;
    fs = 0;
    while (active && budget > 0) begin
      if (abort_at >= 0 && (cyc - start_cyc) == abort_at) break;
      case (mode)
        1: sl = ($urandom_range(99) < 30);
        2: begin
          sl = (issued == TOTAL - 1) && (fs < 3);
          if (sl) fs++;
        end
        default: sl = 1'b0;
      endcase
      tick(hold, sl, 1'b0);
      budget--;
    end
    if (budget == 0) begin
      err_cnt++;
      $error("FAIL sweep_timeout cyc=%0d observed=busy expected=idle", cyc);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    start = 1'b0;
    stall = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    #1;
    check("reset_state", dbg_state, 2'd0);
    check("reset_addr", w_addr_re, 12'h000);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    // unstalled sweep
    tick(1'b1, 1'b0, 1'b0);
    run_sweep(0, 1'b0, -1);
    repeat (3) tick(1'b0, $urandom_range(1), 1'b0);

    // random 30% stall, including stall outside RUN
    tick(1'b1, $urandom_range(1), 1'b0);
    run_sweep(1, 1'b0, -1);
    repeat (3) tick(1'b0, $urandom_range(1), 1'b0);

    // start held high: back-to-back sweeps, reset 1000 cycles into the second
    rise_q.delete();
    tick(1'b1, 1'b0, 1'b0);
    run_sweep(0, 1'b1, -1);
    tick(1'b1, 1'b0, 1'b0);
    run_sweep(0, 1'b1, 1000);
    if (rise_q.size() >= 2) check("restart_gap", rise_q[1] - rise_q[0], 8195);
    else check("restart_count", rise_q.size(), 2);
    tick(1'b0, 1'b0, 1'b1);
    #1;
    check("abort_state", dbg_state, 2'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_poi", POI_addr_re, 8'h00);
    tick(1'b0, 1'b1, 1'b0);

    // fresh sweep after reset, stall held on the final issue
    tick(1'b1, 1'b0, 1'b0);
    run_sweep(2, 1'b0, -1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that drives the ROI/POI fetch stage during mosaic stitching. On a start pulse it walks every POI in the core grid. For each POI it issues 32 window-row reads into the ROI buffer, generating `en`, `w_addr_re`, `POI_addr_re` and `w_row` for the fetch stage. It honours downstream backpressure, tags the fetched data returning one cycle later with valid and last flags, and signals completion to the host-side control.

## Interface
Parameters:
- `ROI_DEPTH`, 6: ROI row-index bits (64 rows).
- `ROI_WIDTH`, 6: ROI column-index bits (64 columns).
- `POI_DEPTH`, 4: POI grid row bits (16).
- `POI_WIDTH`, 4: POI grid column bits (16).
- `WIN_ROWS`, 32: window rows per POI. `w_row` is 5 bits wide, so `WIN_ROWS` ≤ 32.
- `WIN_COLS`, 32: window width in pixels. Used for column clamping.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a sweep. Sampled only in IDLE.
- `stall` in 1: downstream backpressure. Suppresses issue while high.
- `en` out 1: fetch enable, i.e. issue strobe.
- `w_addr_re` out ROI_DEPTH+ROI_WIDTH: ROI address of the first pixel of the window row.
- `POI_addr_re` out POI_DEPTH+POI_WIDTH: POI index `{py,px}`.
- `w_row` out 5: window row index, 0..WIN_ROWS-1.
- `out_valid` out 1: fetch outputs hold valid data this cycle.
- `out_poi_last` out 1: the valid data is the last row of a POI.
- `out_frame_last` out 1: the valid data is the last row of the last POI.
- `busy` out 1: a sweep is in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - If `start`=1, go to RUN.
  - Clear counters `row_cnt`=0 and `poi_cnt`=0.
  - `start` is ignored in every other state.
- RUN:
  - `en` = !`stall`. This is combinational from `stall`; all other outputs are registered.
  - When `en`=1, advance `row_cnt`.
  - When `row_cnt` wraps from WIN_ROWS-1 to 0, increment `poi_cnt`.
  - On an issue with `row_cnt`=WIN_ROWS-1 and `poi_cnt`=all-ones, go to DRAIN.
  - While `stall`=1, counters and addresses hold.
- DRAIN: one cycle, lets the final fetch result emerge. Then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Address generation, all from registered counters:
  - `POI_addr_re` = `poi_cnt`, with `py` = upper POI_DEPTH bits and `px` = lower POI_WIDTH bits.
  - `w_row` = `row_cnt`.
  - `oy` = `py` << (ROI_DEPTH-POI_DEPTH).
  - `ox` = min(`px` << (ROI_WIDTH-POI_WIDTH), 2^ROI_WIDTH - WIN_COLS).
  - `row` = (`oy` + `row_cnt`) truncated to ROI_DEPTH bits, so rows wrap modulo 2^ROI_DEPTH.
  - `w_addr_re` = {`row`, `ox`}.
- Return tagging, registered one cycle after issue to match the fetch stage's one-cycle latency:
  - `out_valid` <= `en`.
  - `out_poi_last` <= `en` && `row_cnt`==WIN_ROWS-1.
  - `out_frame_last` <= `en` && last row && last POI.
- `busy` = 1 in RUN, DRAIN and DONE.
- Reset in any state, including mid-sweep:
  - Next cycle the FSM is in IDLE.
  - All outputs are 0: `en`, `w_addr_re`, `POI_addr_re`, `w_row`, `out_*`, `busy`, `done`.
  - No partial sweep resumes.
- `stall` in IDLE, DRAIN or DONE has no effect.

## Timing
- Cycle 0: `start`=1 in IDLE.
- Cycles 1..8192 (no stall): RUN, `en`=1, one row per cycle.
- Cycle 1 addresses: POI 0, row 0, `w_addr_re`=0.
- Cycle 8193: DRAIN. `out_valid`=`out_poi_last`=`out_frame_last`=1.
- Cycle 8194: `done`=1. `busy` covers cycles 1..8194.
- Cycle 8195: IDLE. `start` is accepted again from this cycle on.
- Each stalled cycle in RUN adds exactly one cycle to total latency.
- `out_valid` = 0 in the cycle after each stalled cycle.
- Issue throughput: 1 row/cycle with no stall.

## Test plan
- Unstalled sweep from `start`:
  - Exactly 8192 `en` cycles and 8192 `out_valid` cycles.
  - `out_poi_last` asserted 256 times; `out_frame_last` once, in cycle 8193.
  - `done` asserted only in cycle 8194.
- Address math:
  - POI 0x5A, row 3 → `w_addr_re`=0x5E0 (`oy`=20, `ox` clamped 40→32, row 23).
  - POI 0xF0, row 5 → `w_addr_re`=0x040 (row 65 wraps to 1).
  - POI 0x07, row 0 → `w_addr_re`=0x01C.
- Random `stall` at 30% duty:
  - Issued address sequence is identical to the unstalled run.
  - `out_valid` count is 8192.
  - Completion is delayed by exactly the number of stalled RUN cycles.
- `start` held high throughout:
  - No restart while `busy`.
  - A second sweep begins in cycle 8196, entering RUN the cycle after IDLE is reached.
- `reset` asserted at cycle 1000:
  - All outputs 0 the following cycle, FSM in IDLE.
  - A new `start` restarts from POI 0, row 0.
- `stall`=1 on the final issue cycle: DRAIN is delayed until the final row issues. `out_frame_last` and `done` are each seen exactly once.
